wave_capture: RTL and testbench
===============================

WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter: SAMPLES_LOG2, default 8, log2 of samples captured per buffer (256).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 new_sample_ready  input  1  one-cycle strobe; new_sample_in valid this cycle (driven from music_player new_sample_generated).
REQ-005 new_sample_in  input  16  signed two's-complement audio sample (music_player sample_out).
REQ-006 wave_display_idle  input  1  high when display is not reading the buffer; swap permitted.
REQ-007 write_address  output  SAMPLES_LOG2+1  RAM write address, {~read_index, sample_count}.
REQ-008 write_enable  output  1  one-cycle RAM write strobe.
REQ-009 write_sample  output  8  offset-binary sample: {~new_sample_in[15], new_sample_in[14:8]}.
REQ-010 read_index  output  1  half of RAM the display reads; capture always writes the other half.

Function
REQ-011 States: ARMED, ACTIVE, WAIT, held in a state register.
REQ-012 Block tracks prev_neg, the sign bit of the last accepted sample; it updates on every new_sample_ready in every state.
REQ-013 Trigger: new_sample_ready high, prev_neg=1 and new_sample_in[15]=0, i.e. a positive-going zero crossing.
REQ-014 ARMED: on trigger, write the triggering sample at count 0, set count to 1 and go to ACTIVE; otherwise stay and write nothing.
REQ-015 ACTIVE: each accepted sample is written at the current count, then count increments.
REQ-016 ACTIVE: the write at count 2^SAMPLES_LOG2-1 moves to WAIT on the same edge; count wraps to 0 and never exceeds the buffer.
REQ-017 WAIT: new_sample_ready produces no write; when wave_display_idle=1, toggle read_index and go to ARMED.
REQ-018 wave_display_idle is ignored in ARMED and ACTIVE; read_index changes only on the WAIT->ARMED transition.
REQ-019 Write latency: write_enable, write_address and write_sample are registered and appear exactly one cycle after the accepting new_sample_ready; write_enable is high for exactly one cycle per write.
REQ-020 write_address uses the read_index value in effect when the sample was accepted.
REQ-021 Samples arriving back-to-back on consecutive cycles are each accepted; no input is dropped in ARMED or ACTIVE.
REQ-022 The WAIT->ARMED transition and a new_sample_ready in the same cycle: the sample updates prev_neg only; no trigger is evaluated that cycle.

Reset
REQ-023 On reset: state=ARMED, count=0, prev_neg=0, read_index=0, write_enable=0, write_address=0, write_sample=0.
REQ-024 Reset asserted mid-capture aborts the buffer; no write_enable is issued in the cycle after reset.
REQ-025 Because prev_neg resets to 0, the first sample after reset never triggers.

Configuration
REQ-026 Macro WAVE_CAPTURE_DECIMATE_EN: when defined, ACTIVE accepts every second new_sample_ready (the 2nd, 4th, ... after the trigger); intervening samples update prev_neg only.
REQ-027 With WAVE_CAPTURE_DECIMATE_EN defined, the triggering sample is still written at count 0, so one buffer spans 2*2^SAMPLES_LOG2-1 input samples.
REQ-028 Without the macro, every new_sample_ready in ACTIVE is written; there is no decimation logic.

Verification
REQ-029 Reset, then samples 0x0100, 0x0200 -> no write_enable, state ARMED, read_index=0.
REQ-030 Samples 0xFF00 then 0x0080 -> one cycle later write_enable=1, write_address=0x100, write_sample=0x80; state ACTIVE.
REQ-031 After trigger, 255 further strobes -> last write at address 0x1FF, state WAIT; the 257th strobe gives no write_enable.
REQ-032 In WAIT, wave_display_idle held 0 for 1000 cycles -> stays WAIT; raise to 1 -> read_index=1 next cycle; next trigger writes start at 0x000.
REQ-033 Reset asserted at count 100 in ACTIVE -> next cycle all outputs are 0 and state is ARMED; sample 0x0010 after reset gives no trigger.
REQ-034 WAVE_CAPTURE_DECIMATE_EN defined, trigger plus 10 strobes -> exactly 6 writes at addresses 0x100-0x105.

Source files
------------

// File: rtl/wave_capture.sv
// wave_capture: zero-crossing-triggered capture of audio samples into a double-buffered display RAM.
// Optional build macro WAVE_CAPTURE_DECIMATE_EN stores every second sample after the trigger.
`default_nettype none

module wave_capture #(
  parameter int SAMPLES_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [15:0]             new_sample_in,
  input  logic                    wave_display_idle,
  output logic [SAMPLES_LOG2:0]   write_address,
  output logic                    write_enable,
  output logic [7:0]              write_sample,
  output logic                    read_index
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [SAMPLES_LOG2-1:0] LAST_COUNT = '1;

  state_t                  state;
  logic [SAMPLES_LOG2-1:0] count;
  logic                    prev_neg;
  logic                    trigger;
  logic [7:0]              sample_ob;
`ifdef WAVE_CAPTURE_DECIMATE_EN
  logic                    phase;
`endif

  assign trigger   = new_sample_ready && prev_neg && !new_sample_in[15];
  assign sample_ob = {~new_sample_in[15], new_sample_in[14:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARMED;
      count         <= '0;
      prev_neg      <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
`ifdef WAVE_CAPTURE_DECIMATE_EN
      phase         <= 1'b0;
`endif
    end else begin
      write_enable <= 1'b0;
      if (new_sample_ready) begin
        prev_neg <= new_sample_in[15];
      end
      case (state)
        ARMED: begin
          if (trigger) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, {SAMPLES_LOG2{1'b0}}};
            write_sample  <= sample_ob;
            count         <= {{(SAMPLES_LOG2-1){1'b0}}, 1'b1};
            state         <= ACTIVE;
`ifdef WAVE_CAPTURE_DECIMATE_EN
            phase         <= 1'b0;
`endif
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
`ifdef WAVE_CAPTURE_DECIMATE_EN
            // Odd-numbered strobes after the trigger are skipped.
            phase <= ~phase;
            if (phase) begin
`else
            begin
`endif
              write_enable  <= 1'b1;
              write_address <= {~read_index, count};
              write_sample  <= sample_ob;
              count         <= count + 1'b1;
              if (count == LAST_COUNT) begin
                state <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          // Triggers are not evaluated here, even on the cycle that re-arms.
          if (wave_display_idle) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end
        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed scoreboard bench for wave_capture (default SAMPLES_LOG2 = 8).
`default_nettype none

module tb_wave_capture;

`ifdef WAVE_CAPTURE_DECIMATE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif
  localparam int ST_ARMED  = 0;
  localparam int ST_ACTIVE = 1;
  localparam int ST_WAIT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = '0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  wave_capture #(.SAMPLES_LOG2(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write seen must match the oldest expected write.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=%0h sample=%0h expected none", write_address, write_sample);
      end
      if (exp_q.size() > 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({write_address, write_sample} === e) else begin
          errors++;
          $error("FAIL write_data: observed=%0h expected=%0h", {write_address, write_sample}, e);
        end
      end
    end
  end

  // Drives one strobe (one cycle) and records the write it should cause.
  task automatic strobe(input logic [15:0] s, input bit exp_wr, input logic [8:0] addr);
    if (exp_wr) exp_q.push_back({addr, ~s[15], s[14:8]});
    new_sample_ready = 1'b1;
    new_sample_in    = s;
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  // Strobe k (1-based) after the trigger: written under decimation only when even.
  function automatic bit wr_after(input int k);
    return !DEC || (k % 2 == 0);
  endfunction

  function automatic int idx_after(input int k);
    return DEC ? k / 2 : k;
  endfunction

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_we", write_enable, 0);
    check("reset_addr", write_address, 0);
    check("reset_sample", write_sample, 0);
    check("reset_ridx", read_index, 0);
    check("reset_state", 32'(dut.state), ST_ARMED);

    // Positive samples only: no trigger.
    strobe(16'h0100, 0, 9'h0);
    strobe(16'h0200, 0, 9'h0);
    @(negedge clk);
    check("armed_state", 32'(dut.state), ST_ARMED);
    check("armed_ridx", read_index, 0);

    // Positive-going crossing triggers at address 0x100.
    strobe(16'hFF00, 0, 9'h0);
    strobe(16'h0080, 1, 9'h100);
    @(negedge clk);
    check("trig_we", write_enable, 1);
    check("trig_addr", write_address, 9'h100);
    check("trig_sample", write_sample, 8'h80);
    check("active_state", 32'(dut.state), ST_ACTIVE);

    // Fill the rest of the buffer back-to-back.
    n = DEC ? 510 : 255;
    for (int i = 1; i <= n; i++) begin
      strobe(16'(i * 16'h0123), wr_after(i), 9'(9'h100 + idx_after(i)));
    end
    @(negedge clk);
    check("full_addr", write_address, 9'h1FF);
    check("wait_state", 32'(dut.state), ST_WAIT);
    strobe(16'h1234, 0, 9'h0);
    strobe(16'h8000, 0, 9'h0);

    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("wait_hold_state", 32'(dut.state), ST_WAIT);
    check("wait_hold_ridx", read_index, 0);

    // Re-arm with a coincident positive sample after a negative one: no trigger.
    @(posedge clk);
    #1;
    wave_display_idle = 1'b1;
    strobe(16'h0100, 0, 9'h0);
    wave_display_idle = 1'b0;
    @(negedge clk);
    check("swap_ridx", read_index, 1);
    check("swap_state", 32'(dut.state), ST_ARMED);

    strobe(16'hF000, 0, 9'h0);
    strobe(16'h0500, 1, 9'h000);
    @(negedge clk);
    check("trig2_addr", write_address, 9'h000);
    check("trig2_state", 32'(dut.state), ST_ACTIVE);

    // Reach count 100, then reset mid-capture.
    n = DEC ? 198 : 99;
    for (int i = 1; i <= n; i++) begin
      strobe(16'(i * 16'h0321), wr_after(i), 9'(idx_after(i)));
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_we", write_enable, 0);
    check("rst_mid_addr", write_address, 0);
    check("rst_mid_sample", write_sample, 0);
    check("rst_mid_ridx", read_index, 0);
    check("rst_mid_state", 32'(dut.state), ST_ARMED);

    strobe(16'h0010, 0, 9'h0);
    @(negedge clk);
    check("post_rst_state", 32'(dut.state), ST_ARMED);

    // Trigger plus ten strobes.
    strobe(16'h8001, 0, 9'h0);
    strobe(16'h0010, 1, 9'h100);
    for (int i = 1; i <= 10; i++) begin
      strobe(16'(16'h0400 + i), wr_after(i), 9'(9'h100 + idx_after(i)));
    end
    repeat (3) @(negedge clk);
    check("tail_addr", write_address, DEC ? 9'h105 : 9'h10A);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
